// File: rtl/dma_controller_pkg.sv
// Shared constants and state encoding for the port-2 block DMA engine.
package dma_controller_pkg;

    localparam int WORD_SIZE       = 16;
    localparam int BLOCK_SIZE      = 64;
    localparam int WORDS_PER_BLOCK = 4;

    localparam logic [WORD_SIZE-1:0] DMA_DEFAULT_ADDR = 16'hF0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        XFER     = 3'd2,
        WAIT_MEM = 3'd3,
        RELEASE  = 3'd4,
        DONE     = 3'd5
    } dma_state_e;

endpackage

// File: rtl/dma_addr_counter.sv
// Block offset counter: produces the current write address (base+offset, 16-bit wrap)
// and flags when the offset has covered the requested length.
module dma_addr_counter
    import dma_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 inc,
    input  logic [WORD_SIZE-1:0] base,
    input  logic [WORD_SIZE-1:0] length,
    output logic [WORD_SIZE-1:0] addr,
    output logic                 last
);

    localparam logic [WORD_SIZE:0] STRIDE = WORDS_PER_BLOCK[WORD_SIZE:0];

    // One extra bit so a length near 0xFFFF cannot wrap the offset and never terminate.
    logic [WORD_SIZE:0] offset_q, offset_d;

    always_comb begin
        offset_d = offset_q;
        if (load) begin
            offset_d = '0;
        end else if (inc) begin
            offset_d = offset_q + STRIDE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
        end
    end

    assign addr = base + offset_q[WORD_SIZE-1:0];
    assign last = (offset_q >= {1'b0, length});

endmodule

// File: rtl/dma_controller.sv
// Bus-master DMA: takes port 2 from the CPU via BR/BG and copies device blocks into
// data memory, one 64-bit block per write, then pulses dma_end_interrupt.
module dma_controller
    import dma_controller_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset_N,
    input  logic                  cmd_valid,
    input  logic [WORD_SIZE-1:0]  cmd_address,
    input  logic [WORD_SIZE-1:0]  cmd_length,
    output logic                  cmd_ready,
    output logic                  BR,
    input  logic                  BG,
    output logic                  dma_writeM2,
    output logic [WORD_SIZE-1:0]  dma_address2,
    output logic [BLOCK_SIZE-1:0] dma_data2,
    input  logic                  M2busy,
    input  logic                  dev_valid,
    input  logic [BLOCK_SIZE-1:0] dev_data,
    output logic                  dev_ack,
    output logic                  dma_busy,
    output logic                  dma_end_interrupt,
    output dma_state_e            dbg_state
);

    // Handshakes: a block moves only in a cycle where BG=1, dev_valid=1 and M2busy=0
    // while in XFER; dma_writeM2 and dev_ack are that same one-cycle strobe, and
    // cmd_valid is accepted only in a cycle where cmd_ready=1.

    dma_state_e            state_q, state_d;
    logic [WORD_SIZE-1:0]  base_q, base_d;
    logic [WORD_SIZE-1:0]  length_q, length_d;
    logic                  skip_q, skip_d;
    logic                  irq_q, irq_d;

    logic                  cnt_load;
    logic                  cnt_inc;
    logic                  wr_fire;
    logic [WORD_SIZE-1:0]  blk_addr;
    logic                  blk_last;

    dma_addr_counter u_addr_counter (
        .clk    (Clk),
        .rst_n  (Reset_N),
        .load   (cnt_load),
        .inc    (cnt_inc),
        .base   (base_q),
        .length (length_q),
        .addr   (blk_addr),
        .last   (blk_last)
    );

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        length_d = length_q;
        skip_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        wr_fire  = 1'b0;
        BR       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    base_d   = cmd_address;
                    length_d = cmd_length;
                    cnt_load = 1'b1;
                    state_d  = (cmd_length == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                BR = 1'b1;
                if (BG) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                BR = 1'b1;
                if (BG && dev_valid && !M2busy) begin
                    wr_fire = 1'b1;
                    cnt_inc = 1'b1;
                    skip_d  = 1'b1;
                    state_d = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                // Memory raises busy one cycle after the write, so the first cycle here is ignored.
                BR = 1'b1;
                if (!skip_q && !M2busy) begin
                    state_d = blk_last ? RELEASE : XFER;
                end
            end
            RELEASE: begin
                if (!BG) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The completion pulse is registered out of DONE, so it appears the cycle after.
    assign irq_d = (state_q == DONE);

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q  <= IDLE;
            base_q   <= '0;
            length_q <= '0;
            skip_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            length_q <= length_d;
            skip_q   <= skip_d;
            irq_q    <= irq_d;
        end
    end

    assign dma_writeM2       = wr_fire;
    assign dev_ack           = wr_fire;
    assign dma_address2      = wr_fire ? blk_addr : '0;
    assign dma_data2         = wr_fire ? dev_data : '0;
    assign cmd_ready         = (state_q == IDLE);
    assign dma_busy          = (state_q != IDLE);
    assign dma_end_interrupt = irq_q;
    assign dbg_state         = state_q;

endmodule
